// File: rtl/line_counter.sv
// line_counter: two raw push-buttons (synchronised, debounced, edge-detected) step a 0..MAX_VAL value.
// Optional macro LINE_COUNTER_AUTOREPEAT_EN adds periodic repeat steps while a button stays held.
module line_counter #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int MAX_VAL         = 31,
    parameter int REPEAT_CYCLES   = 12500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       load,
    input  logic [4:0] load_val,
    output logic [4:0] line,
    output logic       wrap
);
    localparam int               CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [4:0]       MAX_V    = 5'(MAX_VAL);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("line_counter: DEBOUNCE_CYCLES must be >= 1");
    end
    if (MAX_VAL < 1 || MAX_VAL > 31) begin : g_bad_max
        $error("line_counter: MAX_VAL must be in 1..31");
    end
    if (REPEAT_CYCLES < 1) begin : g_bad_repeat
        $error("line_counter: REPEAT_CYCLES must be >= 1");
    end

    function automatic logic [4:0] clamp_val(input logic [4:0] v);
        return (v > MAX_V) ? MAX_V : v;
    endfunction

    function automatic logic [4:0] inc_val(input logic [4:0] v);
        return (v == MAX_V) ? 5'd0 : v + 5'd1;
    endfunction

    function automatic logic [4:0] dec_val(input logic [4:0] v);
        return (v == 5'd0) ? MAX_V : v - 5'd1;
    endfunction

    // Bit 0 carries the up button, bit 1 the down button throughout.
    logic [1:0]       meta_q;
    logic [1:0]       sync_q;
    logic [1:0]       db_q;
    logic [1:0]       db_d;
    logic [1:0]       db_dly_q;
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];
    logic [1:0]       press;
    logic [1:0]       step;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= {btn_down, btn_up};
            sync_q <= meta_q;
        end
    end

    always_comb begin
        db_d     = db_q;
        cnt_d[0] = '0;
        cnt_d[1] = '0;
        for (int b = 0; b < 2; b++) begin
            if (sync_q[b] != db_q[b]) begin
                if (cnt_q[b] == CNT_LAST) begin
                    db_d[b] = sync_q[b];
                end else begin
                    cnt_d[b] = cnt_q[b] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            db_q     <= '0;
            db_dly_q <= '0;
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
        end else begin
            db_q     <= db_d;
            db_dly_q <= db_q;
            cnt_q    <= cnt_d;
        end
    end

    assign press = db_q & ~db_dly_q;

`ifdef LINE_COUNTER_AUTOREPEAT_EN
    localparam int               RPT_W    = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

    logic [RPT_W-1:0] rpt_q [2];
    logic [RPT_W-1:0] rpt_d [2];
    logic [1:0]       held;
    logic [1:0]       rpt_fire;

    // Counting starts the cycle after acceptance, so the first repeat lands REPEAT_CYCLES after the press step.
    assign held = db_q & db_dly_q;

    always_comb begin
        rpt_d[0] = '0;
        rpt_d[1] = '0;
        rpt_fire = '0;
        for (int b = 0; b < 2; b++) begin
            if (held[b] && !load) begin
                if (rpt_q[b] == RPT_LAST) begin
                    rpt_fire[b] = 1'b1;
                end else begin
                    rpt_d[b] = rpt_q[b] + RPT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rpt_q[0] <= '0;
            rpt_q[1] <= '0;
        end else begin
            rpt_q <= rpt_d;
        end
    end

    assign step = press | rpt_fire;
`else
    assign step = press;
`endif

    logic [4:0] line_q;
    logic [4:0] line_d;
    logic       wrap_q;
    logic       wrap_d;

    always_comb begin
        line_d = line_q;
        wrap_d = 1'b0;
        if (load) begin
            line_d = clamp_val(load_val);
        end else if (step[0] ^ step[1]) begin
            if (step[0]) begin
                line_d = inc_val(line_q);
                wrap_d = (line_q == MAX_V);
            end else begin
                line_d = dec_val(line_q);
                wrap_d = (line_q == 5'd0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            line_q <= '0;
            wrap_q <= 1'b0;
        end else begin
            line_q <= line_d;
            wrap_q <= wrap_d;
        end
    end

    assign line = line_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_line_counter.sv
// tb_line_counter: scoreboard bench for line_counter (DEBOUNCE_CYCLES=4, MAX_VAL=9, REPEAT_CYCLES=8).
// Every change of {line, wrap} is matched against the expected cycle and value queued by the stimulus.
module tb_line_counter;
    localparam int DEB  = 4;
    localparam int MAXV = 9;
    localparam int RPT  = 8;
`ifdef LINE_COUNTER_AUTOREPEAT_EN
    localparam int SINGLE_HOLD = 8;
`else
    localparam int SINGLE_HOLD = 20;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_up;
    logic       btn_down;
    logic       load;
    logic [4:0] load_val;
    logic [4:0] line;
    logic       wrap;

    typedef struct {
        int cyc;
        int lv;
        bit w;
    } exp_t;

    exp_t       q[$];
    exp_t       e;
    int         cyc      = 0;
    int         checks   = 0;
    int         failures = 0;
    bit         mon_en   = 1'b0;
    logic [4:0] prev_line;
    logic       prev_wrap;

    line_counter #(
        .DEBOUNCE_CYCLES(DEB),
        .MAX_VAL        (MAXV),
        .REPEAT_CYCLES  (RPT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn_up  (btn_up),
        .btn_down(btn_down),
        .load    (load),
        .load_val(load_val),
        .line    (line),
        .wrap    (wrap)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: any output change pops one expectation; an expectation whose cycle passes unseen is a miss.
    always @(negedge clk) begin
        if (mon_en) begin
            if (line !== prev_line || wrap !== prev_wrap) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_change cyc=%0d actual line=%0d wrap=%0d required no change",
                             cyc, line, wrap);
                end else begin
                    e = q.pop_front();
                    if (e.cyc != cyc || line !== 5'(e.lv) || wrap !== e.w) begin
                        failures++;
                        $display("FAIL update actual cyc=%0d line=%0d wrap=%0d required cyc=%0d line=%0d wrap=%0d",
                                 cyc, line, wrap, e.cyc, e.lv, e.w);
                    end
                end
            end else if (q.size() != 0 && q[0].cyc <= cyc) begin
                checks++;
                failures++;
                e = q.pop_front();
                $display("FAIL missed_update cyc=%0d actual line=%0d wrap=%0d required cyc=%0d line=%0d wrap=%0d",
                         cyc, line, wrap, e.cyc, e.lv, e.w);
            end
            prev_line = line;
            prev_wrap = wrap;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_at(input int off, input int lv, input bit w);
        exp_t x;
        x.cyc = cyc + off;
        x.lv  = lv;
        x.w   = w;
        q.push_back(x);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic do_load(input int v, input int lv_exp);
        @(negedge clk);
        load     = 1'b1;
        load_val = 5'(v);
        expect_at(1, lv_exp, 1'b0);
        @(negedge clk);
        load = 1'b0;
    endtask

    // Press one button at cycle N: line/wrap move at edge N+DEB+3; a wrap clears one cycle later.
    task automatic press(input bit up, input int hold, input int lv, input bit w);
        @(negedge clk);
        if (up) btn_up = 1'b1;
        else    btn_down = 1'b1;
        expect_at(DEB + 3, lv, w);
        if (w) expect_at(DEB + 4, lv, 1'b0);
        idle(hold);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        idle(12);
    endtask

    initial begin
        rst      = 1'b1;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        load     = 1'b0;
        load_val = '0;
        @(negedge clk);
        check("reset_line", 32'(line), 32'd0);
        check("reset_wrap", 32'(wrap), 32'd0);
        @(negedge clk);
        rst       = 1'b0;
        prev_line = line;
        prev_wrap = wrap;
        mon_en    = 1'b1;
        idle(3);

        // Single press, then release: exactly one step.
        press(1'b1, SINGLE_HOLD, 1, 1'b0);

        // Bouncing input (3 high / 1 low) never reaches the debounce threshold.
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            btn_up = 1'b1;
            idle(3);
            btn_up = 1'b0;
            idle(1);
        end
        idle(10);
        check("bounce_hold", 32'(line), 32'd1);
        press(1'b1, 8, 2, 1'b0);

        // Wrap up from MAX_VAL and down from 0.
        do_load(9, 9);
        press(1'b1, 8, 0, 1'b1);
        press(1'b0, 8, 9, 1'b1);

        // Load clamp.
        do_load(5, 5);
        do_load(20, 9);

        // Load in the same cycle as an up step: load wins, the step is lost.
        @(negedge clk);
        btn_up = 1'b1;
        idle(6);
        load     = 1'b1;
        load_val = 5'd2;
        expect_at(1, 2, 1'b0);
        @(negedge clk);
        load   = 1'b0;
        btn_up = 1'b0;
        idle(12);

        // Simultaneous up and down presses cancel.
        @(negedge clk);
        btn_up   = 1'b1;
        btn_down = 1'b1;
        idle(8);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        idle(12);
        check("simul_line", 32'(line), 32'd2);
        check("simul_wrap", 32'(wrap), 32'd0);

        // Plain steps without wrap.
        press(1'b1, 8, 3, 1'b0);
        press(1'b0, 8, 2, 1'b0);

        // Reset mid-debounce with the button held: cleared, then one fresh press after release of rst.
        do_load(7, 7);
        @(negedge clk);
        btn_up = 1'b1;
        idle(3);
        rst = 1'b1;
        expect_at(1, 0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        expect_at(DEB + 3, 1, 1'b0);
        idle(6);
        btn_up = 1'b0;
        idle(12);

        // Long hold: one step, or repeats every RPT cycles when auto-repeat is built in.
        do_load(0, 0);
        @(negedge clk);
        btn_up = 1'b1;
        expect_at(DEB + 3, 1, 1'b0);
`ifdef LINE_COUNTER_AUTOREPEAT_EN
        for (int k = 1; k < 5; k++) expect_at(DEB + 3 + RPT * k, 1 + k, 1'b0);
`endif
        idle(40);
        btn_up = 1'b0;
        idle(20);
`ifdef LINE_COUNTER_AUTOREPEAT_EN
        check("hold_final_line", 32'(line), 32'd5);
`else
        check("hold_final_line", 32'(line), 32'd1);
`endif
        check("queue_drained", 32'(q.size()), 32'd0);

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
